// File: rtl/lcd_frame_capture.sv
// Rebuilds a static 4-common x 33-segment LCD frame from the SM510's multiplexed
// common/segment drive, double-buffered behind a registered random-access read port.
module lcd_frame_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1048576,
    parameter int TO_W    = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  H,
    input  logic [15:0] segA,
    input  logic [15:0] segB,
    input  logic        Bs,
    input  logic [1:0]  rd_com,
    input  logic [5:0]  rd_seg,
    output logic        rd_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        blank
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
    localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SWAP
    } state_t;

    state_t          state, state_n;
    logic [3:0]      h_prev;
    logic [1:0]      com_idx;
    logic [SC_W-1:0] settle_cnt;
    logic [3:0]      row_mask;
    logic [3:0]      mask_wr;
    logic            front_sel;
    logic [TO_W-1:0] to_cnt;
    logic [32:0]     frame_buf [2][4];
    logic [32:0]     front_row;

    logic h_change, h_valid, timeout_hit;
    logic load_com, settle_clr, settle_inc;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] h);
        case (h)
            4'b0010: onehot_to_idx = 2'd1;
            4'b0100: onehot_to_idx = 2'd2;
            4'b1000: onehot_to_idx = 2'd3;
            default: onehot_to_idx = 2'd0;
        endcase
    endfunction

    assign h_change    = (H != h_prev);
    assign h_valid     = (H != 4'd0) && ((H & (H - 4'd1)) == 4'd0);
    assign mask_wr     = row_mask | (4'b0001 << com_idx);
    // Capture owns the counter in its cycle, so a coincident timeout is dropped.
    assign timeout_hit = (state != ST_CAPTURE) && (to_cnt == TO_MAX - TO_W'(1));

    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n    = state;
        load_com   = 1'b0;
        settle_clr = 1'b0;
        settle_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (h_change && h_valid) begin
                    load_com   = 1'b1;
                    settle_clr = 1'b1;
                    state_n    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (h_change) begin
                    if (h_valid) begin
                        load_com   = 1'b1;
                        settle_clr = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_n = ST_CAPTURE;
                end else begin
                    settle_inc = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (com_idx == 2'd3 && mask_wr == 4'b1111)
                    state_n = ST_SWAP;
                else
                    state_n = ST_IDLE;
            end
            ST_SWAP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            h_prev     <= 4'd0;
            com_idx    <= 2'd0;
            settle_cnt <= '0;
            row_mask   <= 4'd0;
            to_cnt     <= '0;
            front_sel  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            blank      <= 1'b1;
        end else begin
            state      <= state_n;
            h_prev     <= H;
            frame_done <= (state == ST_SWAP);

            if (load_com)
                com_idx <= onehot_to_idx(H);

            if (settle_clr)
                settle_cnt <= '0;
            else if (settle_inc)
                settle_cnt <= settle_cnt + SC_W'(1);

            if (state == ST_CAPTURE)
                to_cnt <= '0;
            else if (to_cnt != TO_MAX)
                to_cnt <= to_cnt + TO_W'(1);

            if (state == ST_CAPTURE) begin
                // A common-0 capture outside a completing pass restarts the frame.
                if (com_idx == 2'd0)
                    row_mask <= 4'b0001;
                else
                    row_mask <= mask_wr;
            end else if (state == ST_SWAP || timeout_hit) begin
                row_mask <= 4'd0;
            end

            if (state == ST_SWAP) begin
                front_sel <= ~front_sel;
                frame_cnt <= frame_cnt + 8'd1;
                blank     <= 1'b0;
            end else if (timeout_hit) begin
                blank <= 1'b1;
            end
        end
    end

    // NOTE: the buffers are reset and whole-bank cleared in one cycle, which
    // only flops can do; that is why they are not written as a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 4; r++)
                    frame_buf[b][r] <= '0;
        end else if (state == ST_CAPTURE) begin
            frame_buf[~front_sel][com_idx] <= {Bs, segB, segA};
        end else if (state == ST_SWAP) begin
            for (int r = 0; r < 4; r++)
                frame_buf[front_sel][r] <= '0;
        end
    end

    always_comb front_row = frame_buf[front_sel][rd_com];

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= 1'b0;
        else if (blank || rd_seg > 6'd32)
            rd_data <= 1'b0;
        else
            rd_data <= front_row[rd_seg];
    end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture: read-back tables after known frames plus
// hand-written sequences for resync, glitch, timeout, invalid-H, wrap and reset.
module tb_lcd_frame_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1000;
    localparam int TO_W    = 11;
    localparam int HOLD    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  H;
    logic [15:0] segA, segB;
    logic        Bs;
    logic [1:0]  rd_com;
    logic [5:0]  rd_seg;
    logic        rd_data, frame_done, blank;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_cnt = 0;
    int base;

    typedef struct {
        logic [1:0] com;
        logic [5:0] seg;
        logic       want;
    } rd_vec_t;

    rd_vec_t vecs [12];

    lcd_frame_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .H(H), .segA(segA), .segB(segB), .Bs(Bs),
        .rd_com(rd_com), .rd_seg(rd_seg), .rd_data(rd_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .blank(blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) done_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] h, input logic [15:0] a, input logic [15:0] b,
                         input logic bs, input int hold);
        @(negedge clk);
        H = h; segA = a; segB = b; Bs = bs;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic full_pass(input logic [15:0] a, input logic [15:0] b, input int hold);
        drive(4'b0001, a, b, 1'b0, hold);
        drive(4'b0010, a, b, 1'b0, hold);
        drive(4'b0100, a, b, 1'b1, hold);
        drive(4'b1000, a, b, 1'b0, hold);
    endtask

    task automatic rd_check(input string name, input logic [1:0] c, input logic [5:0] s,
                            input logic want);
        @(negedge clk);
        rd_com = c; rd_seg = s;
        @(negedge clk);
        check(name, {31'd0, rd_data}, {31'd0, want});
    endtask

    initial begin
        vecs[0]  = '{2'd1, 6'd0,  1'b1};
        vecs[1]  = '{2'd1, 6'd1,  1'b0};
        vecs[2]  = '{2'd1, 6'd16, 1'b1};
        vecs[3]  = '{2'd2, 6'd32, 1'b1};
        vecs[4]  = '{2'd1, 6'd32, 1'b0};
        vecs[5]  = '{2'd0, 6'd2,  1'b1};
        vecs[6]  = '{2'd3, 6'd15, 1'b1};
        vecs[7]  = '{2'd3, 6'd17, 1'b1};
        vecs[8]  = '{2'd0, 6'd20, 1'b0};
        vecs[9]  = '{2'd2, 6'd40, 1'b0};
        vecs[10] = '{2'd3, 6'd31, 1'b0};
        vecs[11] = '{2'd0, 6'd24, 1'b1};

        rst = 1'b1; H = 4'd0; segA = '0; segB = '0; Bs = 1'b0; rd_com = '0; rd_seg = '0;
        idle(3);
        rst = 1'b0;
        idle(2);
        check("reset rd_data", {31'd0, rd_data}, 32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        check("reset frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("reset blank", {31'd0, blank}, 32'd1);

        // Basic frame with long holds; the pulse must follow the common-3 capture only.
        drive(4'b0001, 16'hA5A5, 16'h0F0F, 1'b0, 64);
        drive(4'b0010, 16'hA5A5, 16'h0F0F, 1'b0, 64);
        drive(4'b0100, 16'hA5A5, 16'h0F0F, 1'b1, 64);
        check("no early frame_done", done_seen, 0);
        drive(4'b1000, 16'hA5A5, 16'h0F0F, 1'b0, 64);
        exp_cnt++;
        check("frame1 done count", done_seen, 1);
        check("frame1 frame_cnt", {24'd0, frame_cnt}, exp_cnt);
        check("frame1 blank", {31'd0, blank}, 32'd0);
        for (int i = 0; i < 12; i++)
            rd_check($sformatf("frame1 rd c%0d s%0d", vecs[i].com, vecs[i].seg),
                     vecs[i].com, vecs[i].seg, vecs[i].want);

        // 0001,0010,0001,0010,0100,1000: one frame, only after the final 1000.
        base = done_seen;
        drive(4'b0001, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0010, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0001, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0010, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0100, 16'hA5A5, 16'h0F0F, 1'b1, HOLD);
        check("seq2 no done before 1000", done_seen, base);
        drive(4'b1000, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        idle(3);
        exp_cnt++;
        check("seq2 one done", done_seen, base + 1);
        check("seq2 frame_cnt", {24'd0, frame_cnt}, exp_cnt);

        // Resync drops 0010/0100 seen before a later 0001, so 1000 cannot complete.
        base = done_seen;
        drive(4'b0001, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0010, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0100, 16'hA5A5, 16'h0F0F, 1'b1, HOLD);
        drive(4'b0001, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b1000, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        idle(3);
        check("resync no done", done_seen, base);
        drive(4'b0010, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        drive(4'b0100, 16'hA5A5, 16'h0F0F, 1'b1, HOLD);
        drive(4'b1000, 16'hA5A5, 16'h0F0F, 1'b0, HOLD);
        idle(3);
        exp_cnt++;
        check("resync done after rebuild", done_seen, base + 1);

        // Glitch: 0100 held 2 cycles is shorter than SETTLE, so row 2 stays missing.
        base = done_seen;
        drive(4'b0001, 16'h0000, 16'h0000, 1'b0, HOLD);
        drive(4'b0010, 16'h0000, 16'h0000, 1'b0, HOLD);
        drive(4'b0100, 16'hFFFF, 16'hFFFF, 1'b1, 2);
        drive(4'b1000, 16'h0000, 16'h0000, 1'b0, HOLD);
        idle(3);
        check("glitch no done", done_seen, base);
        drive(4'b0100, 16'h1234, 16'h0000, 1'b0, HOLD);
        drive(4'b1000, 16'h0000, 16'h0000, 1'b0, HOLD);
        idle(3);
        exp_cnt++;
        check("glitch completion done", done_seen, base + 1);
        check("glitch frame_cnt", {24'd0, frame_cnt}, exp_cnt);
        rd_check("glitch row2 s0", 2'd2, 6'd0, 1'b0);
        rd_check("glitch row2 s2", 2'd2, 6'd2, 1'b1);
        rd_check("glitch row2 s4", 2'd2, 6'd4, 1'b1);
        rd_check("glitch row2 Bs", 2'd2, 6'd32, 1'b0);

        // Constant H: blank must rise near TIMEOUT cycles after the last capture.
        idle(TIMEOUT - 100);
        check("timeout not yet blank", {31'd0, blank}, 32'd0);
        begin
            int waited = 0;
            while (blank !== 1'b1 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            check("timeout blank", {31'd0, blank}, 32'd1);
        end
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 34; s++)
                rd_check($sformatf("blank rd c%0d s%0d", c, s), 2'(c), 6'(s), 1'b0);
        base = done_seen;
        full_pass(16'hA5A5, 16'h0F0F, HOLD);
        idle(3);
        exp_cnt++;
        check("post-timeout done", done_seen, base + 1);
        check("post-timeout blank", {31'd0, blank}, 32'd0);
        check("post-timeout frame_cnt", {24'd0, frame_cnt}, exp_cnt);
        rd_check("post-timeout rd c0 s0", 2'd0, 6'd0, 1'b1);

        // Invalid H values neither capture nor restart the timeout count.
        base = done_seen;
        for (int i = 0; i < (TIMEOUT - 100) / 4; i++) begin
            drive(4'b0110, 16'hFFFF, 16'hFFFF, 1'b1, 2);
            drive(4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, 2);
        end
        check("invalid H not yet blank", {31'd0, blank}, 32'd0);
        for (int i = 0; i < 50; i++) begin
            drive(4'b0110, 16'hFFFF, 16'hFFFF, 1'b1, 2);
            drive(4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, 2);
        end
        check("invalid H blank", {31'd0, blank}, 32'd1);
        check("invalid H no done", done_seen, base);

        // 256 frames after a reset wrap frame_cnt back to 0.
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_cnt = 0;
        check("rst2 frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst2 blank", {31'd0, blank}, 32'd1);
        base = done_seen;
        for (int f = 0; f < 256; f++)
            full_pass(16'h5555, 16'hAAAA, HOLD);
        idle(3);
        check("256 frames done count", done_seen, base + 256);
        check("256 frames wrap", {24'd0, frame_cnt}, 32'd0);
        full_pass(16'h5555, 16'hAAAA, HOLD);
        full_pass(16'h5555, 16'hAAAA, HOLD);
        idle(3);
        check("two more frames", {24'd0, frame_cnt}, 32'd2);

        // Reset in the middle of common 2 discards the partial pass.
        drive(4'b0001, 16'h5555, 16'hAAAA, 1'b0, HOLD);
        drive(4'b0010, 16'h5555, 16'hAAAA, 1'b0, HOLD);
        drive(4'b0100, 16'h5555, 16'hAAAA, 1'b1, 3);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("midrst frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("midrst blank", {31'd0, blank}, 32'd1);
        rd_check("midrst rd", 2'd0, 6'd0, 1'b0);
        base = done_seen;
        drive(4'b0100, 16'h5555, 16'hAAAA, 1'b1, HOLD);
        drive(4'b1000, 16'h5555, 16'hAAAA, 1'b0, HOLD);
        idle(3);
        check("midrst no done on partial", done_seen, base);
        full_pass(16'h5555, 16'hAAAA, HOLD);
        idle(3);
        check("midrst done after full pass", done_seen, base + 1);
        check("midrst frame_cnt after pass", {24'd0, frame_cnt}, 32'd1);
        check("midrst blank after pass", {31'd0, blank}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
